ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, such as LED set 0xED, reset 0xFF or enable 0xF4, using the standard request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then device ACK. It sits beside the PS/2 receive path on the same ps2_clk/ps2_dat lines. The top level ANDs its open-drain outputs with the receiver's outputs, and the receiver discards frames while `busy` is high.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE,
        ERROR
    } state_t;

    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

    function automatic int unsigned us_to_cycles(input int unsigned freq, input int unsigned us);
        return (freq / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
// Handshake: tx_data is taken on a clock edge where tx_valid and tx_ready are both high;
// tx_valid seen while busy is dropped, tx_done/tx_error are single-cycle status pulses.
interface ps2_host_tx_if;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            tx_done;
    logic            tx_error;
    ps2_pkg::state_t state;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_error, state
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_error, state
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Synchronizes one raw PS/2 line, majority-filters it and flags 1->0 transitions.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic fall
);
    logic s1, s2, h0, h1, filt_q;

    // Idle PS/2 lines are high, so every stage resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            h0     <= 1'b1;
            h1     <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            s1     <= raw;
            s2     <= s1;
            h0     <= s2;
            h1     <= h0;
            filt_q <= filt;
        end
    end

    assign filt = (s2 & h0) | (s2 & h1) | (h0 & h1);
    assign fall = filt_q & ~filt;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// 11-bit frame shifted on device clock falls, then ACK check with timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 28_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 15000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_out,
    output logic         ps2_dat_out,
    ps2_host_tx_if.slave tx
);
    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int          INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int          TO_W        = $clog2(TIMEOUT_CYC + 1);

    state_t             state, state_n;
    logic [7:0]         data_q, data_n;
    logic               parity_q, parity_n;
    logic [3:0]         bit_cnt, bit_cnt_n;
    logic [INH_W-1:0]   inh_cnt, inh_n;
    logic [TO_W-1:0]    to_cnt, to_n;
    logic               clk_q, clk_n, dat_q, dat_n;
    logic               done_q, done_n, err_q, err_n;
    logic               clk_filt, clk_fall, dat_filt, dat_fall_unused;
    logic               accept, timer_run;

    ps2_line_sync u_clk_sync (.clk(clk), .rst(rst), .raw(ps2_clk_in), .filt(clk_filt), .fall(clk_fall));
    ps2_line_sync u_dat_sync (.clk(clk), .rst(rst), .raw(ps2_dat_in), .filt(dat_filt), .fall(dat_fall_unused));

    assign accept    = tx.tx_valid && tx.tx_ready;
    assign timer_run = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            clk_q    <= 1'b1;
            dat_q    <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            data_q   <= data_n;
            parity_q <= parity_n;
            bit_cnt  <= bit_cnt_n;
            inh_cnt  <= inh_n;
            to_cnt   <= to_n;
            clk_q    <= clk_n;
            dat_q    <= dat_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        data_n    = data_q;
        parity_n  = parity_q;
        bit_cnt_n = bit_cnt;
        inh_n     = inh_cnt;
        to_n      = to_cnt;
        clk_n     = clk_q;
        dat_n     = dat_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                clk_n = 1'b1;
                dat_n = 1'b1;
                if (accept) begin
                    data_n    = tx.tx_data;
                    parity_n  = ~^tx.tx_data;
                    bit_cnt_n = '0;
                    inh_n     = INH_W'(INHIBIT_CYC - 1);
                    clk_n     = 1'b0;
                    // A one-cycle inhibit puts the start bit out together with the clock pull.
                    dat_n     = (INHIBIT_CYC > 1);
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == '0) begin
                    clk_n   = 1'b1;
                    state_n = RTS;
                end else begin
                    inh_n = inh_cnt - INH_W'(1);
                    if (inh_cnt == INH_W'(1)) dat_n = 1'b0;
                end
            end
            RTS: begin
                // Loaded so the error pulse lands TIMEOUT_CYC cycles after clock release,
                // counting the ERROR cycle and the pulse cycle itself.
                to_n    = TO_W'(TIMEOUT_CYC - 3);
                state_n = SHIFT;
            end
            SHIFT: begin
                if (clk_fall) begin
                    if (bit_cnt < 4'd8) begin
                        dat_n     = data_q[bit_cnt[2:0]];
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (bit_cnt == 4'd8) begin
                        dat_n     = parity_q;
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else begin
                        dat_n   = 1'b1;
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) state_n = dat_filt ? ERROR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            ERROR: begin
                clk_n   = 1'b1;
                dat_n   = 1'b1;
                err_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Timeout overrides any fall or completion seen in the same cycle.
        if (timer_run) begin
            if (to_cnt == '0) begin
                state_n = ERROR;
                clk_n   = 1'b1;
                dat_n   = 1'b1;
                done_n  = 1'b0;
            end else begin
                to_n = to_cnt - TO_W'(1);
            end
        end
    end

    assign ps2_clk_out = clk_q;
    assign ps2_dat_out = dat_q;
    assign tx.tx_ready = (state == IDLE);
    assign tx.busy     = (state != IDLE);
    assign tx.tx_done  = done_q;
    assign tx.tx_error = err_q;
    assign tx.state    = state;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a PS/2 device model and outcome scoreboard.
module tb_ps2_host_tx;
    localparam int INH = 20;    // 1 MHz clock, 20 us inhibit
    localparam int TO  = 1500;  // 1500 us timeout
    localparam int H   = 8;     // device clock half-period in system cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk_out, ps2_dat_out;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic clk_line, dat_line;

    ps2_host_tx_if bus ();

    assign clk_line = ps2_clk_out & dev_clk;
    assign dat_line = ps2_dat_out & dev_dat;

    ps2_host_tx #(.CLK_FREQ(1_000_000), .INHIBIT_US(20), .TIMEOUT_US(1500)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk_in(clk_line),
        .ps2_dat_in(dat_line),
        .ps2_clk_out(ps2_clk_out),
        .ps2_dat_out(ps2_dat_out),
        .tx(bus.slave)
    );

    // clock/reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];      // expected frame bits, index 0 = start bit
    logic [1:0]  exp_res_q[$];  // expected outcome {tx_error, tx_done}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    // reference model: frame = start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        int v = int'(b);
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((v / (1 << i)) % 2) == 1;
            ones += (v / (1 << i)) % 2;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    // monitor: inhibit timing, release time, outcome pulses, accepts
    int low_cnt = 0, dat_low_at = 0, rel_cyc = 0, last_err_cyc = 0, err_cnt = 0, acc_cnt = 0;
    logic prev_clk_out = 1'b1, prev_pulse = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0; dat_low_at = 0;
            prev_clk_out = 1'b1; prev_pulse = 1'b0; prev_busy = 1'b0;
        end else begin
            if (ps2_clk_out == 1'b0) begin
                low_cnt++;
                if (ps2_dat_out == 1'b0 && dat_low_at == 0) dat_low_at = low_cnt;
            end else begin
                if (prev_clk_out == 1'b0) begin
                    rel_cyc = cyc;
                    check("inhibit_len", low_cnt, INH);
                    check("start_bit_cycle", dat_low_at, INH);
                    check("start_at_release", ps2_dat_out, 1'b0);
                end
                low_cnt = 0; dat_low_at = 0;
            end
            prev_clk_out = ps2_clk_out;
            if (bus.tx_done || bus.tx_error) begin
                check("pulse_exclusive", bus.tx_done & bus.tx_error, 1'b0);
                check("pulse_width", prev_pulse, 1'b0);
                check("ready_with_pulse", bus.tx_ready, 1'b1);
                if (bus.tx_done) check("lines_idle_at_done", {clk_line, dat_line}, 2'b11);
                if (bus.tx_error) begin last_err_cyc = cyc; err_cnt++; end
                if (exp_res_q.size() == 0) fail_now("unexpected_pulse");
                else check("outcome", {bus.tx_error, bus.tx_done}, exp_res_q.pop_front());
            end
            prev_pulse = bus.tx_done | bus.tx_error;
            if (bus.busy && !prev_busy) acc_cnt++;
            prev_busy = bus.busy;
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] b, input int mode);
        int w = 0;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && w < 500) begin @(negedge clk); w++; end
        if (w >= 500) fail_now("ready_wait");
        if (mode == 0 || mode == 1) exp_q.push_back(frame_of(b));
        if (mode == 0) exp_res_q.push_back(2'b01);
        else if (mode == 1 || mode == 2) exp_res_q.push_back(2'b10);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("ready_after_accept", bus.tx_ready, 1'b0);
        check("busy_after_accept", bus.busy, 1'b1);
        check("clk_low_after_accept", ps2_clk_out, 1'b0);
    endtask

    // device model: mode 0 ACK, 1 NACK, 3 stop after the fall that sends bit 4
    task automatic dev_frame(input int mode);
        int w = 0;
        int npulse;
        logic [10:0] got;
        while (!(clk_line === 1'b1 && dat_line === 1'b0) && w < 2000) begin @(negedge clk); w++; end
        if (w >= 2000) begin fail_now("rts_wait"); return; end
        got    = '0;
        got[0] = dat_line;
        npulse = (mode == 3) ? 5 : 10;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= npulse; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (2) @(negedge clk);
            got[i] = dat_line;
            repeat (H - 2) @(negedge clk);
        end
        if (mode == 3) return;
        if (mode == 0) dev_dat = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_dat = 1'b1;
        if (exp_q.size() == 0) fail_now("frame_unexpected");
        else check("frame_bits", got, exp_q.pop_front());
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!bus.tx_ready && w < 300) begin @(negedge clk); w++; end
        if (w >= 300) fail_now("idle_wait");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation ran out of cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int w, e0, a0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_clk_out", ps2_clk_out, 1'b1);
        check("rst_dat_out", ps2_dat_out, 1'b1);
        check("rst_ready", bus.tx_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.tx_done, 1'b0);
        check("rst_error", bus.tx_error, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(8'hED, 0); dev_frame(0); wait_ready();
        send(8'h01, 0); dev_frame(0); wait_ready();
        repeat (4) begin
            b = 8'($urandom_range(0, 255));
            send(b, 0); dev_frame(0); wait_ready();
        end

        // NACK in the ACK slot
        b = 8'($urandom_range(0, 255));
        send(b, 1); dev_frame(1); wait_ready();
        repeat (H) @(negedge clk);
        check("nack_clk_released", ps2_clk_out, 1'b1);
        check("nack_dat_released", ps2_dat_out, 1'b1);
        check("nack_ready", bus.tx_ready, 1'b1);

        // silent device: timeout
        e0 = err_cnt;
        b = 8'($urandom_range(0, 255));
        send(b, 2);
        w = 0;
        while (err_cnt == e0 && w < TO + 200) begin @(negedge clk); w++; end
        if (err_cnt == e0) fail_now("timeout_wait");
        else check("timeout_len", last_err_cyc - rel_cyc, TO);
        @(negedge clk);
        check("timeout_dat_released", ps2_dat_out, 1'b1);

        // reset while bit 4 is on the line
        b = 8'($urandom_range(0, 255));
        send(b, 3); dev_frame(3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_clk_out", ps2_clk_out, 1'b1);
        check("midrst_dat_out", ps2_dat_out, 1'b1);
        check("midrst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'hFF, 0); dev_frame(0); wait_ready();

        // tx_valid held through a frame while the byte changes
        @(negedge clk);
        bus.tx_data  = 8'hF4;
        bus.tx_valid = 1'b1;
        exp_q.push_back(frame_of(8'hF4));
        exp_res_q.push_back(2'b01);
        @(negedge clk); #1;
        a0 = acc_cnt;
        fork
            dev_frame(0);
            begin repeat (40) @(negedge clk); bus.tx_data = 8'h55; end
        join
        exp_q.push_back(frame_of(8'h55));
        exp_res_q.push_back(2'b01);
        w = 0;
        while (!bus.tx_done && w < 300) begin @(negedge clk); w++; end
        if (w >= 300) fail_now("held_done_wait");
        #1;
        check("no_accept_before_done", acc_cnt - a0, 0);
        @(negedge clk); #1;
        check("accept_after_done", acc_cnt - a0, 1);
        check("busy_second", bus.busy, 1'b1);
        bus.tx_valid = 1'b0;
        dev_frame(0); wait_ready();

        repeat (10) @(negedge clk);
        check("frames_left", exp_q.size(), 0);
        check("results_left", exp_res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
